apb_master: RTL and testbench
=============================

# apb_master

APB requester that turns single-beat read/write commands from the ALU-side controller into APB transfers across the three ALU slaves. It decodes the target slave from the address, drives one-hot PSEL plus the shared request bus, and runs the SETUP/ACCESS protocol. It consumes the muxed PREADY/PRDATA/PSLVERR produced by the response arbiter and returns one response per accepted command.

## Interface
- SEL_WIDTH, 3, width of one-hot PSEL; bit0 = slave 1, bit1 = slave 2, bit2 = slave 3
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort (only with APB_MASTER_TIMEOUT_EN)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_error  out  1  slave error, unmapped address or timeout
- o_PSEL  out  SEL_WIDTH  one-hot slave select
- o_PENABLE  out  1  APB enable
- o_PWRITE  out  1  APB direction
- o_PADDR  out  ADDR_WIDTH  APB address
- o_PWDATA  out  DATA_WIDTH  APB write data
- i_PREADY  in  1  muxed ready from arbiter
- i_PRDATA  in  DATA_WIDTH  muxed read data from arbiter
- i_PSLVERR  in  1  muxed slave error from arbiter

## Operation
- States: IDLE, SETUP, ACCESS, RESP. All outputs registered.
- Decode on cmd_addr[ADDR_WIDTH-1:ADDR_WIDTH-2]: 00 -> 3'b001, 01 -> 3'b010, 10 -> 3'b100, 11 -> unmapped.
- IDLE: cmd_ready = 1. On handshake, latch write/addr/wdata/decoded sel. Mapped -> SETUP. Unmapped -> RESP with rsp_error = 1, rsp_rdata = 0; no PSEL activity.
- SETUP: o_PSEL = decoded one-hot, o_PENABLE = 0, PWRITE/PADDR/PWDATA valid. Always -> ACCESS next cycle.
- ACCESS: o_PSEL held, o_PENABLE = 1. PREADY low -> stay. PREADY high -> capture i_PSLVERR into rsp_error; capture i_PRDATA into rsp_rdata only for reads with PSLVERR low, else 0; -> RESP.
- RESP: rsp_valid = 1 for exactly one cycle; o_PSEL = 0, o_PENABLE = 0; -> IDLE.
- cmd_ready = 0 in SETUP, ACCESS, RESP; one outstanding command at most.
- o_PWRITE, o_PADDR, o_PWDATA stable from SETUP through last ACCESS cycle; they hold their last value in IDLE/RESP.
- i_PREADY/i_PRDATA/i_PSLVERR ignored outside ACCESS.

## Timing
- Reset: state IDLE, cmd_ready 1 after release (0 while rst high), all other outputs 0.
- Handshake at edge T -> SETUP in cycle T+1, ACCESS T+2; PREADY high at T+2 -> rsp_valid in T+3; cmd_ready high again in T+4. Each wait state adds one cycle.
- Unmapped: handshake T -> rsp_valid in T+1, cmd_ready high in T+2.
- rst asserted mid-transfer: PSEL/PENABLE drop immediately (async), no rsp_valid for the aborted command, FSM to IDLE.
- Commands presented while cmd_ready = 0 are not accepted and must be held by the source.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: counter clears on entering ACCESS and increments each ACCESS cycle with PREADY low; when it reaches TIMEOUT_CYCLES, next state RESP with rsp_error = 1, rsp_rdata = 0, PSEL/PENABLE deasserted. PREADY in the same cycle as expiry wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

## Test plan
- Write 0x4000_0010 data 0xDEAD_BEEF, PREADY high first ACCESS cycle -> PSEL 3'b010 for 2 cycles, PENABLE only in 2nd, rsp_valid at T+3, rsp_error 0, rsp_rdata 0.
- Read 0x0000_0004, PREADY low 3 cycles then high with PRDATA 0x0000_002A -> PSEL 3'b001 held 5 cycles, rsp_rdata 0x2A, rsp_error 0.
- Read 0x8000_0000 with PSLVERR 1 on ready -> PSEL 3'b100, rsp_error 1, rsp_rdata 0.
- Command to 0xC000_0000 -> PSEL never asserted, rsp_valid at T+1 with rsp_error 1.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES 16, PREADY stuck low -> abort after 16 ACCESS cycles, rsp_error 1; without macro PSEL still high after 100 cycles.
- rst pulsed during ACCESS -> PSEL/PENABLE 0 immediately, no rsp_valid, next command completes normally.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: single-beat commands -> SETUP/ACCESS transfers on one of three decoded slaves.
// Latency: mapped command responds 3 cycles after handshake plus wait states; unmapped responds next cycle.
// Backpressure: cmd_ready low while a command is outstanding; rsp_valid is a one-cycle pulse with no backpressure.
// Optional APB_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES cycles with PREADY low.
module apb_master #(
  parameter int SEL_WIDTH      = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [SEL_WIDTH-1:0]  o_PSEL,
  output logic                  o_PENABLE,
  output logic                  o_PWRITE,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic [DATA_WIDTH-1:0] o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [DATA_WIDTH-1:0] i_PRDATA,
  input  logic                  i_PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [SEL_WIDTH-1:0]  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

  // Top two address bits pick the slave; region 2'b11 has no slave behind it.
  logic [1:0]           region;
  logic                 mapped;
  logic [SEL_WIDTH-1:0] dec_sel;

  assign region  = cmd_addr[ADDR_WIDTH-1 -: 2];
  assign mapped  = (region != 2'b11);
  assign dec_sel = SEL_WIDTH'(1) << region;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (mapped) begin
            state_d  = SETUP;
            psel_d   = dec_sel;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_d     = '0;
`endif
      end
      ACCESS: begin
        if (i_PREADY) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = i_PSLVERR;
          rsp_rdata_d = (!pwrite_q && !i_PSLVERR) ? i_PRDATA : '0;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // The cycle that would bring the count to TIMEOUT_CYCLES ends the wait.
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b0;
        psel_d      = '0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign o_PSEL    = psel_q;
  assign o_PENABLE = penable_q;
  assign o_PWRITE  = pwrite_q;
  assign o_PADDR   = paddr_q;
  assign o_PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, waited read, slave error, unmapped, stuck PREADY, reset abort.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [2:0]  o_PSEL;
  logic        o_PENABLE;
  logic        o_PWRITE;
  logic [31:0] o_PADDR;
  logic [31:0] o_PWDATA;
  logic        i_PREADY;
  logic [31:0] i_PRDATA;
  logic        i_PSLVERR;

  int tests = 0;
  int fails = 0;

  apb_master #(
    .SEL_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE), .o_PWRITE(o_PWRITE),
    .o_PADDR(o_PADDR), .o_PWDATA(o_PWDATA),
    .i_PREADY(i_PREADY), .i_PRDATA(i_PRDATA), .i_PSLVERR(i_PSLVERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command in a cycle where cmd_ready is expected high; returns in cycle T+1.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    chk("cmd_ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    i_PREADY  = 1'b0;
    i_PRDATA  = '0;
    i_PSLVERR = 1'b0;

    // Reset values
    #2;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_psel", {29'd0, o_PSEL}, 32'd0);
    chk("rst_penable", {31'd0, o_PENABLE}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_paddr", o_PADDR, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Write to slave 2, zero wait states
    send(1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
    chk("wr_setup_psel", {29'd0, o_PSEL}, 32'h2);
    chk("wr_setup_penable", {31'd0, o_PENABLE}, 32'd0);
    chk("wr_setup_pwrite", {31'd0, o_PWRITE}, 32'd1);
    chk("wr_setup_paddr", o_PADDR, 32'h4000_0010);
    chk("wr_setup_pwdata", o_PWDATA, 32'hDEAD_BEEF);
    chk("wr_setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    i_PREADY = 1'b1;
    chk("wr_access_psel", {29'd0, o_PSEL}, 32'h2);
    chk("wr_access_penable", {31'd0, o_PENABLE}, 32'd1);
    chk("wr_access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    i_PREADY = 1'b0;
    chk("wr_resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_resp_error", {31'd0, rsp_error}, 32'd0);
    chk("wr_resp_rdata", rsp_rdata, 32'd0);
    chk("wr_resp_psel", {29'd0, o_PSEL}, 32'd0);
    chk("wr_resp_penable", {31'd0, o_PENABLE}, 32'd0);
    chk("wr_resp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("wr_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("wr_idle_paddr_held", o_PADDR, 32'h4000_0010);

    // Read from slave 1 with three wait states
    send(1'b0, 32'h0000_0004, 32'h1111_1111);
    chk("rd_setup_psel", {29'd0, o_PSEL}, 32'h1);
    chk("rd_setup_pwrite", {31'd0, o_PWRITE}, 32'd0);
    tick();
    chk("rd_wait1_penable", {31'd0, o_PENABLE}, 32'd1);
    tick();
    chk("rd_wait2_psel", {29'd0, o_PSEL}, 32'h1);
    tick();
    chk("rd_wait3_penable", {31'd0, o_PENABLE}, 32'd1);
    chk("rd_wait3_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    i_PREADY = 1'b1;
    i_PRDATA = 32'h0000_002A;
    chk("rd_last_access_psel", {29'd0, o_PSEL}, 32'h1);
    chk("rd_last_access_paddr", o_PADDR, 32'h0000_0004);
    tick();
    i_PREADY = 1'b0;
    i_PRDATA = 32'hFFFF_FFFF;
    chk("rd_resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_resp_rdata", rsp_rdata, 32'h0000_002A);
    chk("rd_resp_error", {31'd0, rsp_error}, 32'd0);
    chk("rd_resp_psel", {29'd0, o_PSEL}, 32'd0);
    tick();

    // Read from slave 3 with slave error: data must be dropped
    send(1'b0, 32'h8000_0000, 32'h0);
    chk("err_setup_psel", {29'd0, o_PSEL}, 32'h4);
    tick();
    i_PREADY  = 1'b1;
    i_PSLVERR = 1'b1;
    i_PRDATA  = 32'h0000_1234;
    tick();
    i_PREADY  = 1'b0;
    i_PSLVERR = 1'b0;
    chk("err_resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("err_resp_error", {31'd0, rsp_error}, 32'd1);
    chk("err_resp_rdata", rsp_rdata, 32'd0);
    tick();

    // Unmapped address: immediate error, no bus activity
    send(1'b1, 32'hC000_0000, 32'h5555_5555);
    chk("unm_resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("unm_resp_error", {31'd0, rsp_error}, 32'd1);
    chk("unm_resp_rdata", rsp_rdata, 32'd0);
    chk("unm_psel", {29'd0, o_PSEL}, 32'd0);
    chk("unm_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("unm_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("unm_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("unm_idle_psel", {29'd0, o_PSEL}, 32'd0);

    // PREADY stuck low
    send(1'b0, 32'h0000_0000, 32'h0);
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) tick();
    chk("tmo_last_access_penable", {31'd0, o_PENABLE}, 32'd1);
    chk("tmo_last_access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("tmo_resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("tmo_resp_error", {31'd0, rsp_error}, 32'd1);
    chk("tmo_resp_rdata", rsp_rdata, 32'd0);
    chk("tmo_resp_psel", {29'd0, o_PSEL}, 32'd0);
    chk("tmo_resp_penable", {31'd0, o_PENABLE}, 32'd0);
    tick();
`else
    for (int i = 0; i < 100; i++) tick();
    chk("stuck_psel", {29'd0, o_PSEL}, 32'h1);
    chk("stuck_penable", {31'd0, o_PENABLE}, 32'd1);
    chk("stuck_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    i_PREADY = 1'b1;
    i_PRDATA = 32'h0000_0055;
    tick();
    i_PREADY = 1'b0;
    chk("stuck_release_valid", {31'd0, rsp_valid}, 32'd1);
    chk("stuck_release_rdata", rsp_rdata, 32'h0000_0055);
    tick();
`endif

    // Reset during ACCESS, then a clean transfer
    send(1'b1, 32'h4000_0000, 32'h0000_0001);
    tick();
    chk("rstmid_access_penable", {31'd0, o_PENABLE}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_psel_async", {29'd0, o_PSEL}, 32'd0);
    chk("rstmid_penable_async", {31'd0, o_PENABLE}, 32'd0);
    tick();
    rst = 1'b0;
    chk("rstmid_no_rsp_a", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("rstmid_no_rsp_b", {31'd0, rsp_valid}, 32'd0);
    chk("rstmid_psel_idle", {29'd0, o_PSEL}, 32'd0);
    send(1'b0, 32'h0000_0008, 32'h0);
    chk("after_rst_setup_psel", {29'd0, o_PSEL}, 32'h1);
    tick();
    i_PREADY = 1'b1;
    i_PRDATA = 32'h0000_0077;
    tick();
    i_PREADY = 1'b0;
    chk("after_rst_resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("after_rst_resp_rdata", rsp_rdata, 32'h0000_0077);
    chk("after_rst_resp_error", {31'd0, rsp_error}, 32'd0);
    tick();
    chk("after_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
